// File: rtl/alu.sv
// alu: 32-bit execution-stage ALU with registered result, zero and
// signed-overflow flags. One operation is accepted per clock, with a
// latency of one cycle.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALU_OP,
  output logic [31:0] F,
  output logic        ZF,
  output logic        OF
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  // Addition wraps modulo 2^32. The carry-out is dropped because there is
  // no carry flag.
  function automatic logic signed [31:0] add_wrap(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return a + b;
  endfunction

  // Subtraction wraps modulo 2^32.
  function automatic logic signed [31:0] sub_wrap(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return a - b;
  endfunction

  // Overflow on addition: both operands have the same sign and the sum has
  // the opposite sign.
  function automatic logic add_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  // Overflow on subtraction: the operands differ in sign and the result
  // does not take the sign of the minuend.
  function automatic logic sub_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] sum_s;
  logic signed [31:0] diff_s;
  alu_op_e            op;

  logic [31:0] f_d,  f_q;
  logic        zf_d, zf_q;
  logic        of_d, of_q;

  assign a_s    = A;
  assign b_s    = B;
  assign op     = alu_op_e'(ALU_OP);
  assign sum_s  = add_wrap(a_s, b_s);
  assign diff_s = sub_wrap(a_s, b_s);

  // Combinational result and flags for the operation presented this cycle.
  always_comb begin
    f_d  = '0;
    of_d = 1'b0;
    unique case (op)
      OP_AND: f_d = A & B;
      OP_OR:  f_d = A | B;
      OP_XOR: f_d = A ^ B;
      OP_NOR: f_d = ~(A | B);
      OP_ADD: begin
        f_d  = sum_s;
        of_d = add_ovf(a_s, b_s, sum_s);
      end
      OP_SUB: begin
        f_d  = diff_s;
        of_d = sub_ovf(a_s, b_s, diff_s);
      end
      // SLT uses a true signed comparison. Taking the sign of diff_s would
      // give the wrong answer whenever the subtraction overflows.
      OP_SLT: f_d = {31'd0, (a_s < b_s)};
      OP_SLL: f_d = B << A[4:0];
      default: begin
        f_d  = '0;
        of_d = 1'b0;
      end
    endcase
    zf_d = (f_d == 32'd0);
  end

  // Result and flag registers. Reset loads a zero result, so ZF is set to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q  <= '0;
      zf_q <= 1'b1;
      of_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      zf_q <= zf_d;
      of_q <= of_d;
    end
  end

  assign F  = f_q;
  assign ZF = zf_q;
  assign OF = of_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against a behavioural model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALU_OP;
  logic [31:0] F;
  logic        ZF;
  logic        OF;

  int total;
  int bad;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .ALU_OP (ALU_OP),
    .F      (F),
    .ZF     (ZF),
    .OF     (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Reference model built from plain signed integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, output logic [31:0] r,
                                output logic z, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd5: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = b * (32'd1 << (a % 32));
    endcase
    z = (r == 32'd0);
  endfunction

  // Drive one operation at the falling edge, then check it after the next rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input string tag);
    logic [31:0] r;
    logic z, o;
    @(negedge clk);
    A = a; B = b; ALU_OP = op;
    model(a, b, op, r, z, o);
    @(posedge clk);
    #1;
    chk({tag, ".F"},  F,  r);
    chk({tag, ".ZF"}, {31'd0, ZF}, {31'd0, z});
    chk({tag, ".OF"}, {31'd0, OF}, {31'd0, o});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    A = $urandom; B = $urandom; ALU_OP = 3'd4;

    // Two reset cycles with arbitrary inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      A = $urandom; B = $urandom; ALU_OP = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      chk("rst.F",  F, 32'd0);
      chk("rst.ZF", {31'd0, ZF}, 32'd1);
      chk("rst.OF", {31'd0, OF}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Sweep all eight operations on one operand pair, one op per cycle.
    for (int op = 0; op < 8; op++) begin
      step(32'h1e45d9f9, 32'hd4c41db0, 3'(op), "sweep");
      case (op)
        0: chk("sweep.and", F, 32'h144419b0);
        4: chk("sweep.add", F, 32'hf309f7a9);
        5: chk("sweep.sub", F, 32'h4981bc49);
        6: chk("sweep.slt", F, 32'h00000000);
        7: chk("sweep.sll", F, 32'h60000000);
        default: ;
      endcase
    end

    step(32'h73254ed5, 32'h92292c55, 3'd5, "subovf");
    chk("subovf.Fc", F, 32'he0fc2280);
    chk("subovf.OFc", {31'd0, OF}, 32'd1);
    step(32'h7fffffff, 32'h00000001, 3'd4, "addovf");
    chk("addovf.Fc", F, 32'h80000000);
    chk("addovf.OFc", {31'd0, OF}, 32'd1);
    step(32'hffffffff, 32'h00000001, 3'd4, "wrap");
    chk("wrap.ZFc", {31'd0, ZF}, 32'd1);
    step(32'hd0d65f3d, 32'hd0d65f3d, 3'd5, "zero");
    chk("zero.ZFc", {31'd0, ZF}, 32'd1);
    step(32'h80000000, 32'h7fffffff, 3'd6, "slt");
    chk("slt.Fc", F, 32'd1);
    step(32'h80000000, 32'h7fffffff, 3'd5, "slt_sub");
    chk("slt_sub.OFc", {31'd0, OF}, 32'd1);
    step(32'h7fffffff, 32'h80000000, 3'd6, "slt_rev");
    chk("slt_rev.Fc", F, 32'd0);
    step(32'h00000020, 32'h12345678, 3'd7, "sll0");
    chk("sll0.Fc", F, 32'h12345678);
    step(32'h0000001f, 32'h00000001, 3'd7, "sll31");
    chk("sll31.Fc", F, 32'h80000000);
    step(32'h00000000, 32'h00000000, 3'd3, "nor0");
    chk("nor0.Fc", F, 32'hffffffff);

    // Random back-to-back operations, including edge-heavy operands.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7fffffff;
        1: b = 32'h80000000;
        2: b = a;
        default: ;
      endcase
      step(a, b, 3'($urandom_range(0, 7)), "rand");
    end

    // A reset asserted mid-stream overrides that cycle, then operation resumes.
    @(negedge clk);
    rst = 1'b1; A = 32'h7fffffff; B = 32'h1; ALU_OP = 3'd4;
    @(posedge clk);
    #1;
    chk("midrst.F",  F, 32'd0);
    chk("midrst.ZF", {31'd0, ZF}, 32'd1);
    chk("midrst.OF", {31'd0, OF}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(32'h7fffffff, 32'h00000001, 3'd4, "resume");
    chk("resume.Fc", F, 32'h80000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
